logic_cmd_issuer: RTL and testbench

Command front end for the 32-bit logic unit (AND/OR/XOR, 2-bit select). It accepts operation commands on a valid/ready stream and buffers them in a small FIFO. It drives operands and select to the logic unit from registers, captures the returned result one cycle later, and presents tagged results on a valid/ready output stream. An optional built-in golden check flags any result mismatch.

---
 rtl/logic_pkg.sv | 26 ++
 rtl/cmd_fifo.sv | 56 +++++
 rtl/logic_cmd_issuer.sv | 153 +++++++++++++++
 tb/tb_logic_cmd_issuer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared encodings and types for the logic-unit command front end.
package logic_pkg;

    // Select encodings: bit 1 set means AND whatever bit 0 holds.
    localparam logic [1:0] SEL_XOR = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_AND = 2'b10;

    localparam int SEL_W = 2;
    localparam int TAG_W = 4;
    localparam int LU_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [LU_W-1:0]  a;
        logic [LU_W-1:0]  b;
        logic [TAG_W-1:0] tag;
    } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with full/empty/count and same-cycle push/pop.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            din,
    input  logic                     pop,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/logic_cmd_issuer.sv
// Command front end: buffers logic-unit commands, drives the unit from
// registers, captures its result a cycle later and returns it tagged.
module logic_cmd_issuer
    import logic_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CHECK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    output logic [SEL_W-1:0] lu_sel,
    input  logic [WIDTH-1:0] lu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [SEL_W-1:0] out_sel,
    output logic             busy,
    output logic [15:0]      done_count,
    output logic             err
);

    localparam int CW = SEL_W + 2 * WIDTH + TAG_W;

    state_t                 state, state_nxt;
    logic                   fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [CW-1:0]          fifo_dout;
    logic [SEL_W-1:0]       hd_sel;
    logic [WIDTH-1:0]       hd_a, hd_b;
    logic [TAG_W-1:0]       hd_tag;
    logic [TAG_W-1:0]       tag_p1;
    logic                   pop, capture, complete;

    function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [SEL_W-1:0] sel);
        if ((sel & SEL_AND) != '0) return a & b;
        else if (sel == SEL_OR)    return a | b;
        else                       return a ^ b;
    endfunction

    assign in_ready = !fifo_full;
    assign busy     = (fifo_count != '0) || (state != IDLE);
    assign {hd_sel, hd_a, hd_b, hd_tag} = fifo_dout;

    cmd_fifo #(.DEPTH(DEPTH), .DW(CW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .din   ({in_sel, in_a, in_b, in_tag}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state plus pop/capture/complete strobes.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                capture   = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    complete = 1'b1;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = DRIVE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: operands/select to the logic unit plus tag shadow, held between commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_a   <= '0;
            lu_b   <= '0;
            lu_sel <= '0;
            tag_p1 <= '0;
        end else if (pop) begin
            lu_a   <= hd_a;
            lu_b   <= hd_b;
            lu_sel <= hd_sel;
            tag_p1 <= hd_tag;
        end
    end

    // Stage p2: result capture and output valid; fields frozen while HOLD waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_tag    <= '0;
            out_sel    <= '0;
            out_valid  <= 1'b0;
        end else if (capture) begin
            out_result <= lu_result;
            out_tag    <= tag_p1;
            out_sel    <= lu_sel;
            out_valid  <= 1'b1;
        end else if (complete) begin
            out_valid  <= 1'b0;
        end
    end

    // Completed-handshake counter, wraps at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        done_count <= '0;
        else if (complete) done_count <= done_count + 16'd1;
    end

    // Sticky golden-mismatch flag, set at the capture edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((CHECK != 0) && capture && (golden(lu_a, lu_b, lu_sel) != lu_result)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_cmd_issuer.sv
// Bench for logic_cmd_issuer: bench-side logic unit with fault injection,
// scoreboard model, directed scenarios and a randomized phase.
module tb_logic_cmd_issuer;

    localparam logic [31:0] FAULT_A = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [1:0]  in_sel;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag;
    logic [31:0] lu_a, lu_b, lu_result, lu_true;
    logic [1:0]  lu_sel;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic [1:0]  out_sel;
    logic        busy, err;
    logic [15:0] done_count;

    always #5 clk = ~clk;

    // Bench logic unit; any command whose operand a is FAULT_A gets bit 0 flipped.
    assign lu_true   = lu_sel[1] ? (lu_a & lu_b) : (lu_sel[0] ? (lu_a | lu_b) : (lu_a ^ lu_b));
    assign lu_result = lu_true ^ {31'b0, (lu_a == FAULT_A)};

    logic_cmd_issuer #(.DEPTH(4), .WIDTH(32), .CHECK(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .lu_a(lu_a), .lu_b(lu_b), .lu_sel(lu_sel), .lu_result(lu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_sel(out_sel),
        .busy(busy), .done_count(done_count), .err(err)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [1:0]  sel;
        logic [31:0] res;
        bit          fault;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [15:0] done_exp = 0;
    bit          err_exp = 0;
    bit          hold_prev = 0;
    logic [31:0] prev_res;
    logic [3:0]  prev_tag;
    logic [1:0]  prev_sel;
    int          hs_cyc[$];
    logic [31:0] hs_res[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] s, input logic [31:0] a, b, input logic [3:0] t);
        exp_t e;
        case (s)
            2'b00:   e.res = a ^ b;
            2'b01:   e.res = a | b;
            default: e.res = a & b;
        endcase
        e.fault = (a == FAULT_A);
        if (e.fault) e.res[0] = ~e.res[0];
        e.tag = t;
        e.sel = s;
        return e;
    endfunction

    // Scoreboard: samples on the falling edge, i.e. the values the next rising edge will act on.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                chk("done_count", done_count, done_exp);
                if (hold_prev) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_result", out_result, prev_res);
                    chk("hold_tag", out_tag, prev_tag);
                    chk("hold_sel", out_sel, prev_sel);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("spurious_result", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("result", out_result, e.res);
                        chk("tag", out_tag, e.tag);
                        chk("sel", out_sel, e.sel);
                        err_exp = err_exp | e.fault;
                        chk("err", err, err_exp);
                    end
                    done_exp = done_exp + 16'd1;
                    hs_cyc.push_back(cyc);
                    hs_res.push_back(out_result);
                end
                if (in_valid && in_ready) q.push_back(model(in_sel, in_a, in_b, in_tag));
                hold_prev = out_valid && !out_ready;
                prev_res  = out_result;
                prev_tag  = out_tag;
                prev_sel  = out_sel;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] s, input logic [31:0] a, b, input logic [3:0] t);
        int n = 0;
        in_sel = s; in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
        while (!in_ready && n < 50) begin tick(); n++; end
        if (!in_ready) chk("push_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || out_valid) && n < 300) begin tick(); n++; end
        if (busy || out_valid) chk("idle_timeout", 0, 1);
    endtask

    task automatic model_reset();
        q.delete();
        done_exp  = 0;
        err_exp   = 0;
        hold_prev = 0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [15:0] base;
        rst_n = 1'b0; in_valid = 0; in_sel = 0; in_a = 0; in_b = 0; in_tag = 0; out_ready = 0;
        fork monitor(); join_none

        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_lu_sel", lu_sel, 0);
        chk("rst_done", done_count, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;

        // Single XOR, pushed on the first edge after reset release, latency 2
        in_sel = 2'b00; in_a = 32'hF0F0F0F0; in_b = 32'hFFFF0000; in_tag = 4'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("xor_t0_valid", out_valid, 0);
        tick();
        chk("xor_lu_a", lu_a, 32'hF0F0F0F0);
        chk("xor_lu_b", lu_b, 32'hFFFF0000);
        chk("xor_lu_sel", lu_sel, 2'b00);
        chk("xor_t1_valid", out_valid, 0);
        tick();
        chk("xor_t2_valid", out_valid, 1);
        chk("xor_result", out_result, 32'h0F0FF0F0);
        chk("xor_tag", out_tag, 3);
        tick();
        chk("xor_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("xor_done", done_count, 1);
        chk("xor_valid_clr", out_valid, 0);
        chk("xor_err", err, 0);
        chk("xor_busy", busy, 0);

        // Back-to-back AND then OR with out_ready high
        hs_cyc.delete(); hs_res.delete();
        push(2'b10, 32'h12345678, 32'h0000FFFF, 4'd1);
        push(2'b01, 32'h12345678, 32'h0000FFFF, 4'd2);
        wait_idle();
        chk("b2b_count", hs_res.size(), 2);
        if (hs_res.size() == 2) begin
            chk("b2b_and", hs_res[0], 32'h00005678);
            chk("b2b_or", hs_res[1], 32'h1234FFFF);
            chk("b2b_spacing", hs_cyc[1] - hs_cyc[0], 2);
        end

        // Backpressure: 4 in FIFO plus 1 in flight, then drain in order
        out_ready = 1'b0;
        base = done_exp;
        for (int i = 0; i < 5; i++) push(2'(i % 3), 32'hA5A50000 + i, 32'h0F0F0F0F, 4'(8 + i));
        chk("bp_in_ready", in_ready, 0);
        chk("bp_busy", busy, 1);
        in_sel = 2'b00; in_a = 32'h1; in_b = 32'h2; in_tag = 4'hF; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_refuse", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        chk("bp_done", done_count, base + 16'd5);
        chk("bp_queue_empty", q.size(), 0);

        // Fault on the 2nd command: err sticks through later correct results
        push(2'b01, 32'h00000010, 32'h00000001, 4'd4);
        chk("fault_pre_err", err, 0);
        push(2'b00, FAULT_A, 32'h00000000, 4'd5);
        push(2'b10, 32'hFFFFFFFF, 32'h0000000F, 4'd6);
        wait_idle();
        chk("fault_err", err, 1);
        push(2'b11, 32'h33333333, 32'hFFFF0000, 4'd7);
        wait_idle();
        chk("fault_err_sticky", err, 1);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            if (ra == FAULT_A) ra = ra ^ 32'h1;
            in_valid = 1'($urandom_range(0, 1));
            in_sel = 2'($urandom_range(0, 3));
            in_a = ra; in_b = $urandom; in_tag = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        chk("rand_drained", q.size(), 0);

        // Reset while in DRIVE with 3 commands queued
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(2'b00, 32'h100 + i, 32'h0, 4'(i));
        out_ready = 1'b1;
        tick();
        chk("mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done_count, 0);
        chk("mid_in_ready", in_ready, 1);
        chk("mid_err", err, 0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("mid_no_stale", out_valid, 0);
        chk("mid_idle", busy, 0);

        // done_count wrap from a preloaded value
        force dut.done_count = 16'hFFFD;
        done_exp = 16'hFFFD;
        #1;
        release dut.done_count;
        #1;
        chk("wrap_preload", done_count, 16'hFFFD);
        for (int i = 0; i < 3; i++) push(2'b01, 32'h0, 32'h5 + i, 4'(i));
        wait_idle();
        chk("wrap_zero", done_count, 16'h0000);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout got=%0t want=<900000", $time);
        $fatal(1, "timeout");
    end

endmodule
